cpu_multicycle: RTL
===================

// Module: cpu_multicycle
// PURPOSE
//   Parametrised multi-cycle successor to the single-cycle 8-bit core. Executes the same
//   8-bit instruction format through a FETCH/EXEC/MEM/WB state machine. Instruction and
//   data memories are external behind req/ack handshakes, so wait-state memories are legal.
//   Sits between the board clock tree and the memory blocks; seven-segment output is optional.
// PARAMETERS
//   DATA_W    8   register/ALU/data-memory width (>=4); 2-bit immediates sign-extended to DATA_W
//   PC_W      8   program counter and instruction address width
//   RESET_PC  0   PC value loaded on clear
// PORTS
//   clock        in   1       single system clock, all state on rising edge
//   clear        in   1       synchronous active-high reset
//   run          in   1       1 = leave IDLE and keep executing; 0 = stop after current instr
//   imem_req     out  1       instruction fetch request, held until imem_ack
//   imem_addr    out  PC_W    fetch address (= pc)
//   imem_data    in   8       instruction, sampled in the cycle imem_ack=1
//   imem_ack     in   1       fetch complete; may rise in the same cycle as imem_req
//   dmem_req     out  1       data access request, held until dmem_ack
//   dmem_we      out  1       1 = store, 0 = load; valid while dmem_req=1
//   dmem_addr    out  DATA_W  rs1 + sext(imm)
//   dmem_wdata   out  DATA_W  r[rs2] for stores
//   dmem_rdata   in   DATA_W  load data, sampled in the cycle dmem_ack=1
//   dmem_ack     in   1       data access complete
//   pc_out       out  PC_W    current pc
//   retire       out  1       1-cycle pulse when an instruction completes (WB state)
//   wb_en        out  1       1-cycle pulse when a register is written
//   wb_reg       out  2       destination register of that write
//   wb_data      out  DATA_W  value written
//   first_segment  out 7      hex digit of wb_data[7:4], gfedcba active-high
//   second_segment out 7      hex digit of wb_data[3:0]
// BEHAVIOUR
//   Encoding: op=ir[7:6], rs1=ir[5:4], rs2=ir[3:2], imm/rd=ir[1:0].
//     00 ADD  r[rd]  <= r[rs1]+r[rs2]
//     01 LW   r[rs2] <= mem[r[rs1]+sext(imm)]
//     10 SW   mem[r[rs1]+sext(imm)] <= r[rs2]
//     11 BEQ  if r[rs1]==r[rs2] then pc <= pc+1+sext(imm)
//   Arithmetic is modulo 2^DATA_W (addresses/data) and 2^PC_W (pc); no flags, no traps.
//   States: IDLE -> FETCH when run=1; FETCH -> EXEC on imem_ack (ir latched);
//     EXEC -> MEM for LW/SW, else -> WB; MEM -> WB on dmem_ack (LW data latched);
//     WB -> FETCH if run=1, else -> IDLE.
//   In WB: pc updated (pc+1 or branch target); retire=1; wb_en=1 for ADD/LW only.
//   Latency with zero-wait memories: ADD/BEQ 3 cycles, LW/SW 4 cycles.
//   Each wait cycle extends FETCH or MEM by 1; req and address stay stable until ack.
//   ack when req=0 is ignored. run falling mid-instruction: instruction completes, then IDLE.
//   Register reads occur in EXEC and see all prior WB writes (no hazards, one instr in flight).
//   Reset values: state=IDLE, pc=RESET_PC, r0..r3=0, ir=0, all req/we/retire/wb_en=0,
//     wb_reg=0, wb_data=0, dmem_addr/wdata=0.
//   clear mid-access drops req in the following cycle; in-flight instruction is discarded.
//     A late ack is ignored in IDLE.
// CONFIGURATION
//   WB_SEG_EN defined: segments decode the last value driven on wb_data.
//     Updates on wb_en and holds between writes; shows "00" (7'h3F,7'h3F) after clear.
//   WB_SEG_EN undefined: no decoders built; both segment ports tied to 7'h00 (blank).
// TESTING
//   1. clear, r1=3,r2=4 preloaded by LW; ADD r3=r1+r2 (0x1B) with ack same cycle
//      -> wb_en, wb_reg=3, wb_data=7, retire 3 cycles after FETCH entry.
//   2. LW r2,[r1-1] with r1=5, dmem_ack delayed 3 cycles -> dmem_addr=4 held stable 4 cycles;
//      wb_data=mem[4]; total 7 cycles.
//   3. SW r2,[r0+1] with r2=0x5A -> dmem_we=1, addr=1, wdata=0x5A; retire=1, wb_en=0.
//   4. BEQ taken at pc=0x10, imm=2'b10 -> next imem_addr=0x0F; not-taken -> 0x11.
//      At pc=0xFF taken, imm=01 -> pc wraps to 0x01.
//   5. run=0 during MEM of LW -> LW retires, FSM IDLE, imem_req stays 0.
//      clear during FETCH wait -> imem_req=0 next cycle, pc=RESET_PC.
//   6. DATA_W=16: ADD 0xFFFF+0x0002 -> 0x0001.
//      WB_SEG_EN on: wb_data=0x3C -> first_segment=7'h4F, second_segment=7'h39.

Source files
------------

// File: rtl/cpu_multicycle_if.sv
// Instruction/data memory handshake bundle for cpu_multicycle.
// master = core side, slave = memory side; req is held until ack.
interface cpu_multicycle_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) ();
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [7:0]        imem_data;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_data, imem_ack, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_data, imem_ack, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle core for the 8-bit ADD/LW/SW/BEQ ISA: FETCH/EXEC/MEM/WB with req/ack memories.
// Optional macro WB_SEG_EN: seven-segment decode of the last register write-back value.
module cpu_multicycle #(
    parameter int              DATA_W   = 8,
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    cpu_multicycle_if.master    bus,
    output logic [PC_W-1:0]     pc_out,
    output logic                retire,
    output logic                wb_en,
    output logic [1:0]          wb_reg,
    output logic [DATA_W-1:0]   wb_data,
    output logic [6:0]          first_segment,
    output logic [6:0]          second_segment
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_LW, OP_SW, OP_BEQ} op_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t            state, state_nx;
    op_t               op;
    logic [PC_W-1:0]   pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_ext;
    logic [PC_W-1:0]   br_off;
    logic              br_taken;
    logic [DATA_W-1:0] dmem_addr_q, dmem_wdata_q;
    logic              dmem_we_q;

    assign op      = op_t'(ir[7:6]);
    assign rs1_val = regs[ir[5:4]];
    assign rs2_val = regs[ir[3:2]];
    assign imm_ext = {{(DATA_W-2){ir[1]}}, ir[1:0]};
    assign br_off  = {{(PC_W-2){ir[1]}}, ir[1:0]};

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.dmem_we    = dmem_we_q;
    assign pc_out         = pc;
    assign wb_reg         = (op == OP_LW) ? ir[3:2] : ir[1:0];
    assign wb_data        = result;

    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        retire       = 1'b0;
        wb_en        = 1'b0;
        case (state)
            S_IDLE:  if (run) state_nx = S_FETCH;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) state_nx = S_EXEC;
            end
            S_EXEC:  state_nx = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
            S_MEM: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ack) state_nx = S_WB;
            end
            S_WB: begin
                retire   = 1'b1;
                wb_en    = (op == OP_ADD || op == OP_LW);
                state_nx = run ? S_FETCH : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operands are read once in EXEC; the address, store data and branch decision
    // are captured there so they stay stable for the whole MEM/WB phase.
    always_ff @(posedge clock) begin
        if (clear) begin
            pc           <= RESET_PC;
            ir           <= '0;
            result       <= '0;
            br_taken     <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (bus.imem_ack) ir <= bus.imem_data;
                S_EXEC: begin
                    dmem_addr_q  <= rs1_val + imm_ext;
                    dmem_wdata_q <= rs2_val;
                    dmem_we_q    <= (op == OP_SW);
                    br_taken     <= (op == OP_BEQ) && (rs1_val == rs2_val);
                    if (op == OP_ADD) result <= rs1_val + rs2_val;
                end
                S_MEM: if (bus.dmem_ack && !dmem_we_q) result <= bus.dmem_rdata;
                S_WB: begin
                    pc <= pc + PC_ONE + (br_taken ? br_off : '0);
                    if (wb_en) regs[wb_reg] <= result;
                end
                default: ;
            endcase
        end
    end

`ifdef WB_SEG_EN
    logic [7:0] seg_byte;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (clear)      seg_byte <= '0;
        else if (wb_en) seg_byte <= 8'(result);
    end

    assign first_segment  = hex7(seg_byte[7:4]);
    assign second_segment = hex7(seg_byte[3:0]);
`else
    assign first_segment  = 7'h00;
    assign second_segment = 7'h00;
`endif
endmodule
